// File: rtl/mul4_vector_scorer.sv
// Fitness stage for 2x16-bit-limb multiplier candidates: drives LFSR operands into a
// combinational candidate, compares its limbs with the golden product and accumulates scores.
module mul4_vector_scorer #(
    parameter int unsigned NUM_VECTORS = 256,
    parameter logic [63:0] SEED        = 64'hACE1,
    parameter int unsigned SCORE_W     = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic [15:0]        a1,
    output logic [15:0]        a0,
    output logic [15:0]        b1,
    output logic [15:0]        b0,
    input  logic [15:0]        y3,
    input  logic [15:0]        y2,
    input  logic [15:0]        y1,
    input  logic [15:0]        y0,
    output logic               busy,
    output logic               done,
    output logic [SCORE_W-1:0] limb_score,
    output logic [SCORE_W-1:0] bit_score,
    output logic               perfect
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    localparam logic [63:0]        SEED_EFF = (SEED == 64'h0) ? 64'h1 : SEED;
    localparam int unsigned        CNT_W    = (NUM_VECTORS > 1) ? $clog2(NUM_VECTORS) : 1;
    localparam logic [CNT_W-1:0]   LAST_VEC = CNT_W'(NUM_VECTORS - 1);
    localparam int unsigned        SUM_W    = SCORE_W + 8;
    localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};

    generate
        if (NUM_VECTORS < 1) begin : g_bad_num_vectors
            $error("mul4_vector_scorer: NUM_VECTORS must be >= 1");
        end
    endgenerate

    state_t             state_q, state_d;
    logic [63:0]        lfsr_q, lfsr_d;
    logic [CNT_W-1:0]   vec_cnt_q, vec_cnt_d;
    logic               cmp_valid_q, cmp_valid_d;
    logic [2:0]         m_limb_q, m_limb_d;
    logic [6:0]         m_bit_q, m_bit_d;
    logic [SCORE_W-1:0] limb_score_q, limb_score_d;
    logic [SCORE_W-1:0] bit_score_q, bit_score_d;
    logic               perfect_q, perfect_d;

    logic        in_run;
    logic [31:0] op_a, op_b;
    logic [63:0] golden, y_cat, same_bits;
    logic [2:0]  cmp_limb;
    logic [6:0]  cmp_bit;

    function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] acc,
                                                   input logic [6:0]         inc);
        logic [SUM_W-1:0] sum;
        sum = SUM_W'(acc) + SUM_W'(inc);
        return (sum > SUM_W'(SCORE_MAX)) ? SCORE_MAX : sum[SCORE_W-1:0];
    endfunction

    assign in_run = (state_q == S_RUN);
    assign op_a   = in_run ? lfsr_q[63:32] : 32'h0;
    assign op_b   = in_run ? lfsr_q[31:0]  : 32'h0;
    assign {a1, a0} = op_a;
    assign {b1, b0} = op_b;

    assign golden    = {32'h0, op_a} * {32'h0, op_b};
    assign y_cat     = {y3, y2, y1, y0};
    assign same_bits = ~(y_cat ^ golden);

    // An X on y makes the equality/bit test unknown, so the if is not taken: X scores as a miss.
    always_comb begin
        cmp_limb = 3'd0;
        cmp_bit  = 7'd0;
        for (int i = 0; i < 4; i++) begin
            if (y_cat[16*i +: 16] == golden[16*i +: 16]) cmp_limb = cmp_limb + 3'd1;
        end
        for (int i = 0; i < 64; i++) begin
            if (same_bits[i]) cmp_bit = cmp_bit + 7'd1;
        end
    end

    // NOTE: every _d gets its hold value first, so no path through this block can infer a latch.
    always_comb begin
        state_d      = state_q;
        lfsr_d       = lfsr_q;
        vec_cnt_d    = vec_cnt_q;
        cmp_valid_d  = cmp_valid_q;
        m_limb_d     = m_limb_q;
        m_bit_d      = m_bit_q;
        limb_score_d = limb_score_q;
        bit_score_d  = bit_score_q;
        perfect_d    = perfect_q;

        if (cmp_valid_q) begin
            limb_score_d = sat_add(limb_score_q, {4'd0, m_limb_q});
            bit_score_d  = sat_add(bit_score_q, m_bit_q);
            perfect_d    = perfect_q & (m_limb_q == 3'd4);
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d      = S_RUN;
                    lfsr_d       = SEED_EFF;
                    vec_cnt_d    = '0;
                    cmp_valid_d  = 1'b0;
                    limb_score_d = '0;
                    bit_score_d  = '0;
                    perfect_d    = 1'b1;
                end
            end
            S_RUN: begin
                // Fibonacci taps 64,63,61,60 map to bits 63,62,60,59.
                lfsr_d      = {lfsr_q[62:0], lfsr_q[63] ^ lfsr_q[62] ^ lfsr_q[60] ^ lfsr_q[59]};
                cmp_valid_d = 1'b1;
                m_limb_d    = cmp_limb;
                m_bit_d     = cmp_bit;
                if (vec_cnt_q == LAST_VEC) state_d = S_DRAIN;
                else                       vec_cnt_d = vec_cnt_q + 1'b1;
            end
            S_DRAIN: begin
                cmp_valid_d = 1'b0;
                state_d     = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state updates use non-blocking assignment so all flops sample pre-edge values.
    // NOTE: every flop, including the LFSR, is reset so a mid-run abort leaves no stale state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            lfsr_q       <= '0;
            vec_cnt_q    <= '0;
            cmp_valid_q  <= 1'b0;
            m_limb_q     <= '0;
            m_bit_q      <= '0;
            limb_score_q <= '0;
            bit_score_q  <= '0;
            perfect_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            lfsr_q       <= lfsr_d;
            vec_cnt_q    <= vec_cnt_d;
            cmp_valid_q  <= cmp_valid_d;
            m_limb_q     <= m_limb_d;
            m_bit_q      <= m_bit_d;
            limb_score_q <= limb_score_d;
            bit_score_q  <= bit_score_d;
            perfect_q    <= perfect_d;
        end
    end

    assign busy       = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign done       = (state_q == S_DONE);
    assign limb_score = limb_score_q;
    assign bit_score  = bit_score_q;
    assign perfect    = perfect_q;

endmodule
